// File: rtl/channel_mixer_pkg.sv
// channel_mixer_pkg
//   Shared constants for the channel mixer slice:
//     mixer_state_t - FSM state encoding (ACCUM gathers samples, OUTPUT presents result)
//     MODE_WRAP     - SATURATE value selecting modulo-2^WIDTH wraparound
//     MODE_SAT      - SATURATE value selecting clamp-to-all-ones on carry
package channel_mixer_pkg;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } mixer_state_t;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

endpackage

// File: rtl/channel_mixer_sat_adder.sv
// sat_adder
//   Combinational unsigned adder with optional saturation.
//   Ports:
//     lhs, rhs  in  [WIDTH-1:0] unsigned operands
//     result    out [WIDTH-1:0] sum, clamped to all-ones on carry when SATURATE=MODE_SAT,
//                               otherwise the low WIDTH bits of the sum
//     overflow  out             carry out of the WIDTH-bit add
module sat_adder
  import channel_mixer_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned SATURATE = MODE_SAT
) (
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum    = {1'b0, lhs} + {1'b0, rhs};
    overflow = w_sum[WIDTH];
    if (w_sum[WIDTH] && (SATURATE == MODE_SAT)) begin
      result = '1;
    end else begin
      result = w_sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/channel_mixer.sv
// channel_mixer
//   Sums CHANNELS unsigned samples per frame and presents the result with a
//   valid/ready handshake. Frames never overlap: while a result is pending no
//   sample is accepted, and the handshake edge itself accepts nothing.
//   Ports:
//     clk          in   single clock, rising edge
//     rst          in   asynchronous active-high reset
//     in_sample    in   [WIDTH-1:0] sample for channel in_channel
//     in_valid     in   in_sample is valid
//     in_ready     out  mixer accepts a sample this cycle (state ACCUM)
//     in_channel   out  [$clog2(CHANNELS)-1:0] index of the channel expected next
//     out_sample   out  [WIDTH-1:0] mixed frame result
//     out_overflow out  at least one add in the frame carried out
//     out_valid    out  out_sample/out_overflow valid (state OUTPUT)
//     out_ready    in   consumer takes the result
module channel_mixer
  import channel_mixer_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SATURATE = MODE_SAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in_sample,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [$clog2(CHANNELS)-1:0] in_channel,
  output logic [WIDTH-1:0]            out_sample,
  output logic                        out_overflow,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int unsigned CW = $clog2(CHANNELS);
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  mixer_state_t r_state;
  mixer_state_t w_next_state;

  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [CW-1:0]    r_chan;
  logic [WIDTH-1:0] r_out_sample;
  logic             r_out_ovf;

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_accept;
  logic             w_last;
  logic             w_handshake;

  sat_adder #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_sat_adder (
    .lhs      (r_acc),
    .rhs      (in_sample),
    .result   (w_sum),
    .overflow (w_carry)
  );

  assign w_accept    = (r_state == ACCUM) && in_valid;
  assign w_last      = (r_chan == LAST_CH);
  assign w_handshake = (r_state == OUTPUT) && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACCUM:   if (w_accept && w_last) w_next_state = OUTPUT;
      OUTPUT:  if (out_ready)          w_next_state = ACCUM;
      default: w_next_state = ACCUM;
    endcase
  end

  // Datapath: accumulator, sticky carry, channel counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_chan       <= '0;
      r_out_sample <= '0;
      r_out_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_ovf <= r_ovf | w_carry;
      if (w_last) begin
        // Capture the final sum directly from the adder so the result is
        // visible one edge after the last accept.
        r_out_sample <= w_sum;
        r_out_ovf    <= r_ovf | w_carry;
        r_chan       <= '0;
      end else begin
        r_chan <= r_chan + 1'b1;
      end
    end else if (w_handshake) begin
      r_acc  <= '0;
      r_ovf  <= 1'b0;
      r_chan <= '0;
    end
  end

  assign in_ready     = (r_state == ACCUM);
  assign out_valid    = (r_state == OUTPUT);
  assign in_channel   = r_chan;
  assign out_sample   = r_out_sample;
  assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_channel_mixer.sv
module tb_channel_mixer;
  import channel_mixer_pkg::*;

  localparam int unsigned W  = 12;
  localparam int unsigned CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_sample;
  logic          in_valid;
  logic          out_ready;

  logic          s_in_ready,  w_in_ready;
  logic [1:0]    s_in_channel, w_in_channel;
  logic [W-1:0]  s_out_sample, w_out_sample;
  logic          s_out_ovf,   w_out_ovf;
  logic          s_out_valid, w_out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  channel_mixer #(.WIDTH(W), .CHANNELS(CH), .SATURATE(MODE_SAT)) dut_sat (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_channel(s_in_channel), .out_sample(s_out_sample),
    .out_overflow(s_out_ovf), .out_valid(s_out_valid), .out_ready(out_ready)
  );

  channel_mixer #(.WIDTH(W), .CHANNELS(CH), .SATURATE(MODE_WRAP)) dut_wrap (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(w_in_ready), .in_channel(w_in_channel), .out_sample(w_out_sample),
    .out_overflow(w_out_ovf), .out_valid(w_out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [3:0][W-1:0] s;
    logic [W-1:0]      sat_exp;
    logic              sat_ovf;
    logic [W-1:0]      wrap_exp;
    logic              wrap_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of input, advance past the next rising edge.
  task automatic cyc(input logic v, input logic [W-1:0] s);
    in_valid  = v;
    in_sample = s;
    @(posedge clk);
    #1;
  endtask

  // Accept four samples, checking channel index and handshake flags en route.
  task automatic feed4(input logic [3:0][W-1:0] s);
    for (int k = 0; k < 4; k++) begin
      chk("in_channel_pre", int'(s_in_channel), k);
      chk("in_ready_accum", int'(s_in_ready), 1);
      chk("out_valid_accum", int'(s_out_valid), 0);
      cyc(1'b1, s[k]);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    out_ready = 1'b1;
    feed4(v.s);
    chk("sat_out_valid",  int'(s_out_valid), 1);
    chk("wrap_out_valid", int'(w_out_valid), 1);
    chk("sat_in_ready_out", int'(s_in_ready), 0);
    chk("sat_out_sample", int'(s_out_sample), int'(v.sat_exp));
    chk("sat_out_ovf",    int'(s_out_ovf),    int'(v.sat_ovf));
    chk("wrap_out_sample", int'(w_out_sample), int'(v.wrap_exp));
    chk("wrap_out_ovf",    int'(w_out_ovf),    int'(v.wrap_ovf));
    chk("chan_wrapped", int'(s_in_channel), 0);
    cyc(1'b0, '0);
    chk("out_valid_one_cycle", int'(s_out_valid), 0);
    chk("in_ready_after_hs",   int'(s_in_ready), 1);
  endtask

  logic [3:0][W-1:0] fr;
  logic [6:0] gap_v;
  logic [6:0][W-1:0] gap_s;
  logic [6:0][1:0] gap_ch;

  initial begin
    vecs[0] = '{s: {12'd10, 12'd10, 12'd5, 12'd5},       sat_exp: 12'd30,  sat_ovf: 1'b0, wrap_exp: 12'd30,  wrap_ovf: 1'b0};
    vecs[1] = '{s: {12'h000, 12'h000, 12'h001, 12'hFFF}, sat_exp: 12'hFFF, sat_ovf: 1'b1, wrap_exp: 12'h000, wrap_ovf: 1'b1};
    vecs[2] = '{s: {12'h000, 12'h000, 12'h002, 12'hFFF}, sat_exp: 12'hFFF, sat_ovf: 1'b1, wrap_exp: 12'h001, wrap_ovf: 1'b1};
    vecs[3] = '{s: {12'h002, 12'h001, 12'h800, 12'h800}, sat_exp: 12'hFFF, sat_ovf: 1'b1, wrap_exp: 12'h003, wrap_ovf: 1'b1};
    vecs[4] = '{s: {12'h3FF, 12'h400, 12'h400, 12'h400}, sat_exp: 12'hFFF, sat_ovf: 1'b0, wrap_exp: 12'hFFF, wrap_ovf: 1'b0};
    vecs[5] = '{s: {12'h000, 12'h000, 12'h000, 12'h000}, sat_exp: 12'h000, sat_ovf: 1'b0, wrap_exp: 12'h000, wrap_ovf: 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready",   int'(s_in_ready), 1);
    chk("rst_out_valid",  int'(s_out_valid), 0);
    chk("rst_in_channel", int'(s_in_channel), 0);
    chk("rst_out_sample", int'(s_out_sample), 0);
    chk("rst_out_ovf",    int'(s_out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Stall in OUTPUT with in_valid asserted; nothing may be accepted,
    // including on the handshake edge.
    out_ready = 1'b0;
    fr = {12'd4, 12'd3, 12'd2, 12'd1};
    feed4(fr);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 12'd7);
      chk("stall_out_valid",  int'(s_out_valid), 1);
      chk("stall_in_ready",   int'(s_in_ready), 0);
      chk("stall_out_sample", int'(s_out_sample), 10);
      chk("stall_in_channel", int'(s_in_channel), 0);
    end
    out_ready = 1'b1;
    cyc(1'b1, 12'd7);
    in_valid = 1'b0;
    chk("hs_out_valid",  int'(s_out_valid), 0);
    chk("hs_in_channel", int'(s_in_channel), 0);
    fr = {12'd1, 12'd1, 12'd1, 12'd1};
    feed4(fr);
    chk("post_stall_valid",  int'(s_out_valid), 1);
    chk("post_stall_sample", int'(s_out_sample), 4);
    cyc(1'b0, '0);

    // Reset mid-frame.
    cyc(1'b1, 12'd100);
    cyc(1'b1, 12'd200);
    in_valid = 1'b0;
    chk("mid_in_channel", int'(s_in_channel), 2);
    rst = 1'b1;
    #1;
    chk("async_rst_channel", int'(s_in_channel), 0);
    chk("async_rst_ready",   int'(s_in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    fr = {12'd4, 12'd3, 12'd2, 12'd1};
    feed4(fr);
    chk("after_rst_sample", int'(s_out_sample), 10);
    chk("after_rst_ovf",    int'(s_out_ovf), 0);
    cyc(1'b0, '0);

    // Reset while a result is pending.
    out_ready = 1'b0;
    fr = {12'd9, 12'd9, 12'd9, 12'd9};
    feed4(fr);
    chk("pend_out_valid", int'(s_out_valid), 1);
    rst = 1'b1;
    #1;
    chk("pend_rst_valid",  int'(s_out_valid), 0);
    chk("pend_rst_sample", int'(s_out_sample), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Gapped in_valid: 3,x,x,4,x,5,6 -> 18.
    gap_v  = 7'b1101001;
    gap_s  = {12'd6, 12'd5, 12'hABC, 12'd4, 12'hABC, 12'hABC, 12'd3};
    gap_ch = {2'd0, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    for (int g = 0; g < 7; g++) begin
      cyc(gap_v[g], gap_s[g]);
      chk("gap_in_channel", int'(s_in_channel), int'(gap_ch[g]));
    end
    in_valid = 1'b0;
    chk("gap_out_valid",  int'(s_out_valid), 1);
    chk("gap_out_sample", int'(s_out_sample), 18);
    chk("gap_wrap_sample", int'(w_out_sample), 18);
    cyc(1'b0, '0);
    chk("gap_hs_valid", int'(s_out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
